// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU data-side bus controller and its
// lane alignment helper.
package cpu_bus_pkg;

  // Controller states: no done state, completion is a registered pulse.
  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  // Access size as a one-hot vector {w, h, b}.
  typedef logic [2:0] size_t;

  localparam size_t SZ_W = 3'b100;
  localparam size_t SZ_H = 3'b010;
  localparam size_t SZ_B = 3'b001;

  // Byte enables, bit k = byte lane k (little-endian).
  localparam logic [3:0] BE_W  = 4'b1111;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;

  // Default number of cycles a request may wait for an ack.
  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/bus_lane_align.sv
// Combinational byte-lane helper: byte enables and store replication for a
// request, and lane extraction plus sign/zero extension for load data.
module bus_lane_align
  import cpu_bus_pkg::*;
(
  input  size_t       size_i,
  input  logic [1:0]  off_i,
  input  logic        zext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [15:0] half_v;
  logic [7:0]  byte_v;

  // Select the addressed half and byte of the returned bus word.
  always_comb begin
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (off_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
  end

  // Enables, replicated store data and extended load data per access size.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_W: begin
        be_o = BE_W;
      end
      SZ_H: begin
        be_o    = off_i[1] ? BE_H1 : BE_H0;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~zext_i & half_v[15]}}, half_v};
      end
      SZ_B: begin
        unique case (off_i)
          2'd0:    be_o = BE_B0;
          2'd1:    be_o = BE_B1;
          2'd2:    be_o = BE_B2;
          default: be_o = BE_B3;
        endcase
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~zext_i & byte_v[7]}}, byte_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// Data-side bus controller: accepts one load/store at a time from the CPU
// memory stage, checks alignment, runs a req/ack bus transaction with byte
// enables and returns extended load data with a one-cycle done pulse.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_w,
  input  logic        cpu_h,
  input  logic        cpu_b,
  input  logic        cpu_z,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bc_req,
  output logic        bc_rw,
  output logic [31:0] bc_addr,
  output logic [31:0] bc_wdata,
  output logic [3:0]  bc_be,
  input  logic [31:0] bc_rdata,
  input  logic        bc_ack
);

  state_e      state_q, state_d;
  size_t       req_size;
  logic        size_ok, align_ok, legal, accept, timeout_hit;

  // Latched request, held stable on the bus for the whole transaction.
  logic        rw_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  size_t       size_q;
  logic        z_q;
  logic [CNT_W-1:0] cnt_q;

  // Registered completion outputs and their next values.
  logic        done_q, done_d;
  logic        addr_err_q, addr_err_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] rdata_q, rdata_d;

  // Lane helper: live request fields in IDLE, latched fields in BUS.
  size_t       al_size;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign req_size = {cpu_w, cpu_h, cpu_b};

  // Legality check of the request currently offered by the CPU.
  always_comb begin
    size_ok  = (req_size == SZ_W) || (req_size == SZ_H) || (req_size == SZ_B);
    align_ok = !(cpu_w && (cpu_addr[1:0] != 2'b00)) && !(cpu_h && cpu_addr[0]);
    legal    = size_ok && align_ok;
  end

  assign accept      = (state_q == IDLE) && cpu_req && legal;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  assign al_size = (state_q == BUS) ? size_q : req_size;
  assign al_off  = (state_q == BUS) ? off_q  : cpu_addr[1:0];

  bus_lane_align u_align (
    .size_i  (al_size),
    .off_i   (al_off),
    .zext_i  (z_q),
    .wdata_i (cpu_wdata),
    .rdata_i (bc_rdata),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

  // State register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: ack wins over a timeout on the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUS;
      BUS:  if (bc_ack || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: completion pulses, load result and pipeline stall.
  always_comb begin
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    rdata_d    = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req && !legal) begin
          addr_err_d = 1'b1;
          done_d     = 1'b1;
        end
      end
      BUS: begin
        if (bc_ack) begin
          done_d  = 1'b1;
          rdata_d = rw_q ? 32'h0 : al_rdata;
        end else if (timeout_hit) begin
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cpu_stall = (state_q == BUS) || accept;

  // Request latch and wait counter for the bus transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
      off_q   <= 2'b00;
      size_q  <= SZ_W;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      rw_q    <= cpu_rw;
      addr_q  <= {cpu_addr[31:2], 2'b00};
      wdata_q <= al_wdata;
      be_q    <= al_be;
      off_q   <= cpu_addr[1:0];
      size_q  <= req_size;
      z_q     <= cpu_z;
      cnt_q   <= '0;
    end else if ((state_q == BUS) && !bc_ack) begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Registered completion pulses and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign cpu_done  = done_q;
  assign cpu_rdata = rdata_q;
  assign addr_err  = addr_err_q;
  assign bus_err   = bus_err_q;
  assign bc_req    = (state_q == BUS);
  assign bc_rw     = rw_q;
  assign bc_addr   = addr_q;
  assign bc_wdata  = wdata_q;
  assign bc_be     = be_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl: expected completions are queued when a
// request is driven and compared when the controller pulses cpu_done.
module tb_cpu_bus_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0, cpu_rw = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_w = 1'b0, cpu_h = 1'b0, cpu_b = 1'b0, cpu_z = 1'b0;
  logic        cpu_stall, cpu_done, addr_err, bus_err;
  logic [31:0] cpu_rdata;
  logic        bc_req, bc_rw;
  logic [31:0] bc_addr, bc_wdata;
  logic [3:0]  bc_be;
  logic [31:0] bc_rdata = '0;
  logic        bc_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_err;
    int          done_cyc;
  } exp_t;

  exp_t sb_q[$];

  cpu_bus_ctrl #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_rw    (cpu_rw),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_w     (cpu_w),
    .cpu_h     (cpu_h),
    .cpu_b     (cpu_b),
    .cpu_z     (cpu_z),
    .cpu_stall (cpu_stall),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .bc_req    (bc_req),
    .bc_rw     (bc_rw),
    .bc_addr   (bc_addr),
    .bc_wdata  (bc_wdata),
    .bc_be     (bc_be),
    .bc_rdata  (bc_rdata),
    .bc_ack    (bc_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: size is {w,h,b}; ack_k < 0 means the slave never acks.
  task automatic run_txn(input string tag, input logic rw, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] size, input logic z,
                         input int ack_k, input logic [31:0] bus_rd, input logic exp_legal,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata, input logic exp_berr);
    exp_t e;
    int   cyc, req_cyc, stall_cyc, exp_busy;
    logic done_seen;
    e.rdata    = exp_rdata;
    e.addr_err = !exp_legal;
    e.bus_err  = exp_berr;
    e.done_cyc = !exp_legal ? 1 : (ack_k >= 0 ? 2 + ack_k : 1 + TMO);
    exp_busy   = !exp_legal ? 0 : (ack_k >= 0 ? ack_k + 1 : TMO);

    @(negedge clk);
    cpu_req   = 1'b1;
    cpu_rw    = rw;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    {cpu_w, cpu_h, cpu_b} = size;
    cpu_z     = z;
    bc_rdata  = bus_rd;
    sb_q.push_back(e);
    #1 check({tag, "_stall_T"}, cpu_stall, exp_legal);

    @(negedge clk);
    cpu_req = 1'b0;
    cyc = 1; req_cyc = 0; stall_cyc = 0; done_seen = 1'b0;
    if (exp_legal) begin
      check({tag, "_be"}, bc_be, exp_be);
      check({tag, "_addr"}, bc_addr, {addr[31:2], 2'b00});
      check({tag, "_wdata"}, bc_wdata, exp_wdata);
      check({tag, "_rw"}, bc_rw, rw);
    end
    while (cyc < 40) begin
      if (cpu_done) begin
        done_seen = 1'b1;
        break;
      end
      if (bc_req) req_cyc++;
      if (cpu_stall) stall_cyc++;
      bc_ack = (ack_k >= 0) && (cyc == 1 + ack_k);
      @(negedge clk);
      cyc++;
    end
    bc_ack = 1'b0;

    check({tag, "_done_seen"}, done_seen, 1'b1);
    check({tag, "_req_cycles"}, req_cyc, exp_busy);
    check({tag, "_stall_cycles"}, stall_cyc, exp_busy);
    if (done_seen) begin
      check({tag, "_sb_nonempty"}, sb_q.size() > 0, 1'b1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({tag, "_done_cycle"}, cyc, e.done_cyc);
        check({tag, "_rdata"}, cpu_rdata, e.rdata);
        check({tag, "_addr_err"}, addr_err, e.addr_err);
        check({tag, "_bus_err"}, bus_err, e.bus_err);
        check({tag, "_req_in_done"}, bc_req, 1'b0);
        check({tag, "_stall_in_done"}, cpu_stall, 1'b0);
      end
    end
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_done", cpu_done, 1'b0);
    check("rst_rdata", cpu_rdata, 32'h0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_req", bc_req, 1'b0);
    check("rst_rw", bc_rw, 1'b0);
    check("rst_addr", bc_addr, 32'h0);
    check("rst_wdata", bc_wdata, 32'h0);
    check("rst_be", bc_be, 4'b0000);
    check("rst_stall", cpu_stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Loads: word with 3 wait cycles, byte/half lanes with sign and zero extension
    run_txn("ld_w", 1'b0, 32'h100, 32'h0, 3'b100, 1'b0, 3, 32'h8899AABB, 1'b1,
            4'b1111, 32'h0, 32'h8899AABB, 1'b0);
    run_txn("ld_b_s", 1'b0, 32'h103, 32'h0, 3'b001, 1'b0, 0, 32'h80112233, 1'b1,
            4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
    run_txn("ld_b_z", 1'b0, 32'h103, 32'h0, 3'b001, 1'b1, 1, 32'h80112233, 1'b1,
            4'b1000, 32'h0, 32'h00000080, 1'b0);
    run_txn("ld_h_s", 1'b0, 32'h102, 32'h0, 3'b010, 1'b0, 0, 32'h80112233, 1'b1,
            4'b1100, 32'h0, 32'hFFFF8011, 1'b0);
    run_txn("ld_h_z", 1'b0, 32'h100, 32'h0, 3'b010, 1'b1, 2, 32'h1234F00D, 1'b1,
            4'b0011, 32'h0, 32'h0000F00D, 1'b0);

    // Stores: replicated lanes, result is zero
    run_txn("st_h", 1'b1, 32'h202, 32'h1234ABCD, 3'b010, 1'b0, 1, 32'hDEADBEEF, 1'b1,
            4'b1100, 32'hABCDABCD, 32'h0, 1'b0);
    run_txn("st_b", 1'b1, 32'h001, 32'h0000005A, 3'b001, 1'b0, 0, 32'hDEADBEEF, 1'b1,
            4'b0010, 32'h5A5A5A5A, 32'h0, 1'b0);
    run_txn("st_w", 1'b1, 32'h040, 32'hCAFEBABE, 3'b100, 1'b0, 0, 32'h0, 1'b1,
            4'b1111, 32'hCAFEBABE, 32'h0, 1'b0);

    // Illegal requests
    run_txn("bad_w_align", 1'b0, 32'h101, 32'h0, 3'b100, 1'b0, 0, 32'h0, 1'b0,
            4'b0000, 32'h0, 32'h0, 1'b0);
    run_txn("bad_wh", 1'b0, 32'h100, 32'h0, 3'b110, 1'b0, 0, 32'h0, 1'b0,
            4'b0000, 32'h0, 32'h0, 1'b0);
    run_txn("bad_h_align", 1'b1, 32'h201, 32'h0, 3'b010, 1'b0, 0, 32'h0, 1'b0,
            4'b0000, 32'h0, 32'h0, 1'b0);
    run_txn("bad_none", 1'b0, 32'h100, 32'h0, 3'b000, 1'b0, 0, 32'h0, 1'b0,
            4'b0000, 32'h0, 32'h0, 1'b0);

    // Timeout with no ack, then ack on the final allowed cycle
    run_txn("tmo", 1'b0, 32'h300, 32'h0, 3'b100, 1'b0, -1, 32'h11111111, 1'b1,
            4'b1111, 32'h0, 32'h0, 1'b1);
    run_txn("ack_last", 1'b0, 32'h304, 32'h0, 3'b100, 1'b0, TMO - 1, 32'h22223333, 1'b1,
            4'b1111, 32'h0, 32'h22223333, 1'b0);

    // Reset while a transaction is outstanding
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_rw   = 1'b0;
    cpu_addr = 32'h500;
    {cpu_w, cpu_h, cpu_b} = 3'b100;
    @(negedge clk);
    cpu_req = 1'b0;
    check("mid_req_high", bc_req, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", bc_req, 1'b0);
    check("mid_rst_stall", cpu_stall, 1'b0);
    check("mid_rst_be", bc_be, 4'b0000);
    check("mid_rst_addr", bc_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_txn("post_rst", 1'b0, 32'h400, 32'h0, 3'b100, 1'b0, 3, 32'hCAFEF00D, 1'b1,
            4'b1111, 32'h0, 32'hCAFEF00D, 1'b0);

    check("sb_drained", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_ctrl.md
# cpu_bus_ctrl

Data-side bus controller sitting directly downstream of the CPU's memory stage. It takes one load/store request at a time (address, store data, access size w/h/b, zero-extend flag) and checks alignment. It runs a req/ack transaction on the external system bus with byte-lane enables, then returns aligned, sign- or zero-extended load data. While a transaction is outstanding it holds a stall to the pipeline; misaligned accesses and bus timeouts are reported as error pulses.

## Interface
- `TIMEOUT`, 255: maximum cycles `bc_req` stays high without `bc_ack` before a bus error (≥2).
- `CNT_W`, 8: timeout counter width; `2**CNT_W` ≥ `TIMEOUT`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `cpu_req` in 1: access request, level, sampled only in IDLE.
- `cpu_rw` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: byte address.
- `cpu_wdata` in 32: store data, right-justified.
- `cpu_w`, `cpu_h`, `cpu_b` in 1 each: access size word/half/byte; exactly one must be high.
- `cpu_z` in 1: 1 = zero-extend load, 0 = sign-extend.
- `cpu_stall` out 1: freeze pipeline (combinational).
- `cpu_done` out 1: one-cycle completion pulse, registered.
- `cpu_rdata` out 32: load result, valid while `cpu_done`=1.
- `addr_err` out 1: one-cycle pulse for misaligned or illegal size.
- `bus_err` out 1: one-cycle pulse on timeout.
- `bc_req` out 1: bus request, registered.
- `bc_rw` out 1: bus direction.
- `bc_addr` out 32: word address, `{cpu_addr[31:2],2'b00}`.
- `bc_wdata` out 32: lane-replicated store data.
- `bc_be` out 4: byte enables, bit k = byte lane k.
- `bc_rdata` in 32: bus read data, valid with `bc_ack`.
- `bc_ack` in 1: slave completion, one cycle.

## Operation
- FSM states are IDLE and BUS. There is no separate done state; `cpu_done` is a registered pulse.
- IDLE with `cpu_req`=1 runs the legality check:
  - Illegal if the size is not one-hot, or a word access has `addr[1:0]`≠0, or a half access has `addr[0]`≠0.
  - Illegal: the next cycle pulses `addr_err`=1 and `cpu_done`=1 with `cpu_rdata`=0. No bus activity. The FSM stays in IDLE.
  - Legal: latch rw, address, lanes and data, then go to BUS.
- Byte lanes are little-endian: byte at `addr[1:0]`=k is lane k, bits [8k+7:8k].
  - Enables: w gives `1111`, h gives `0011<<addr[1]*2`, b gives `0001<<addr[1:0]`.
  - Store data: w is passed through, h is `{2{wdata[15:0]}}`, b is `{4{wdata[7:0]}}`.
  - Loads extract the addressed lane, then sign-extend (`cpu_z`=0) or zero-extend (`cpu_z`=1). Word loads pass through.
  - `bc_be` is also driven on loads.
- In BUS: `bc_req`=1 and all `bc_*` outputs are held stable. `bc_ack` is ignored outside BUS.
  - On `bc_ack`: register the extended `cpu_rdata` (stores give 0), pulse `cpu_done`, and return to IDLE.
  - The counter clears on BUS entry and increments each BUS cycle without ack.
  - If the counter reaches `TIMEOUT-1` with no ack, pulse `bus_err` and `cpu_done` with `cpu_rdata`=0, then return to IDLE.
  - An ack arriving on that final cycle wins: normal completion, no `bus_err`.
- `cpu_stall` = (state==BUS) | (state==IDLE & `cpu_req` & legal).
- Reset values: state IDLE and counter 0. Every output is 0, including `bc_be`=0, `bc_addr`=0 and `bc_wdata`=0.
- Reset mid-transaction: `bc_req` drops asynchronously and the transaction is abandoned. The slave must tolerate request withdrawal.

## Timing
- Request accepted at cycle T. `bc_req` is high from T+1.
- Ack at T+1+k (k≥0): `bc_req` is low and `cpu_done`/`cpu_rdata` are valid at T+2+k.
- Minimum load-to-result latency is 2 cycles.
- `cpu_stall` is high from T through T+1+k and low in the done cycle.
- A new `cpu_req` can be accepted in the done cycle, giving back-to-back transactions with one idle bus cycle between them.
- Misaligned request at T: `addr_err`/`cpu_done` at T+1. `cpu_stall` is never asserted for it.
- Timeout: `bc_req` is high for exactly `TIMEOUT` cycles, and `bus_err` is at T+1+`TIMEOUT`.

## Structure
- Shared package `cpu_bus_pkg` holds:
  - the state enum (IDLE, BUS);
  - the size one-hot constants;
  - the BE constants `BE_W`/`BE_H0`/`BE_H1`/`BE_B0..3`;
  - the default `TIMEOUT`.
- Sub-module `bus_lane_align` (combinational) generates BE and store replication and performs load extraction and extension. It is reused by the instruction side later.

## Test plan
- Word load, addr 0x100, ack after 3 wait cycles, `bc_rdata`=0x8899AABB -> `bc_be`=1111, `bc_addr`=0x100, `cpu_done` at T+5 with `cpu_rdata`=0x8899AABB. Stall high T..T+4.
- Byte load, addr 0x103, `cpu_z`=0, `bc_rdata`=0x80112233 -> `bc_be`=1000, `cpu_rdata`=0xFFFFFF80. Repeat with `cpu_z`=1 -> 0x00000080.
- Half store, addr 0x202, wdata 0x1234ABCD -> `bc_be`=1100, `bc_wdata`=0xABCDABCD, `bc_rw`=1, `cpu_rdata`=0.
- Word access at 0x101, and a request with w=h=1 -> `addr_err` and `cpu_done` at T+1, `bc_req` never rises, no stall.
- No ack with `TIMEOUT`=4 -> `bc_req` high 4 cycles, `bus_err` pulse. Then ack exactly on cycle 4 -> normal done, no `bus_err`.
- Assert `rst`=0 mid-BUS -> `bc_req` low immediately. After release, a fresh word load completes normally with the counter restarted.
